// File: rtl/tdc7200_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tdc7200_spi_responder                                           |
// | Brief    : SPI mode-0 slave model of the TDC7200 register interface.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tdc7200_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int MEAS_W      = 24
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sclk,
  input  logic              csb,
  input  logic              din,
  output logic              dout,
  output logic              intb,
  input  logic              meas_we,
  input  logic [3:0]        meas_addr,
  input  logic [MEAS_W-1:0] meas_data,
  input  logic              meas_done,
  output logic              start_meas,
  output logic [7:0]        cfg1,
  output logic [7:0]        cfg2
);

  localparam int c_CNT_W    = $clog2(MEAS_W + 1);
  localparam int c_NUM_MEAS = 12;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_csb_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic                   r_sclk_d;
  logic                   r_csb_d;
  logic                   w_sclk;
  logic                   w_csb;
  logic                   w_din;
  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_csb_fall;
  logic                   w_csb_rise;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_CNT_W-1:0]     r_bitcnt;
  logic [MEAS_W-1:0]      r_shift;
  logic                   r_ai;
  logic [5:0]             r_addr;
  logic                   r_dout;
  logic                   r_intb;
  logic                   r_start_meas;
  logic [7:0]             r_config1;
  logic [7:0]             r_config2;
  logic [7:0]             r_int_mask;
  logic                   r_new_meas;
  logic [7:0]             r_ovf [4];
  logic [7:0]             r_stop_mask [2];
  logic [MEAS_W-1:0]      r_meas [c_NUM_MEAS];

  logic [7:0]             w_cmd_byte;
  logic [MEAS_W-1:0]      w_wword;
  logic [7:0]             w_wr_byte;
  logic [c_CNT_W-1:0]     w_word_bits;
  logic                   w_word_last;
  logic [5:0]             w_next_addr;
  logic [5:0]             w_rd_addr;
  logic [7:0]             w_rd_byte;
  logic [MEAS_W-1:0]      w_rd_word;
  logic                   w_cmd_last;
  logic                   w_wr_commit;
  logic                   w_rd_word_end;

  // Synchronizers are left unreset so a reset while csb is held low does not
  // fabricate a chip-select edge.
  always_ff @(posedge clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
    r_csb_sync  <= {r_csb_sync[SYNC_STAGES-2:0], csb};
    r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], din};
    r_sclk_d    <= w_sclk;
    r_csb_d     <= w_csb;
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_csb       = r_csb_sync[SYNC_STAGES-1];
  assign w_din       = r_din_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_csb_fall  = ~w_csb & r_csb_d;
  assign w_csb_rise  = w_csb & ~r_csb_d;

  assign w_cmd_byte  = {r_shift[6:0], w_din};
  assign w_wword     = {r_shift[MEAS_W-2:0], w_din};
  assign w_wr_byte   = w_wword[7:0];
  assign w_word_bits = (r_addr[5:4] != 2'b00) ? c_CNT_W'(MEAS_W) : c_CNT_W'(8);
  assign w_word_last = (r_bitcnt == (w_word_bits - c_CNT_W'(1)));
  assign w_next_addr = r_ai ? (r_addr + 6'd1) : r_addr;
  assign w_rd_addr   = (r_state == S_CMD) ? w_cmd_byte[5:0] : w_next_addr;

  // Read data is left-aligned so the shift-out path is width independent.
  always_comb begin
    w_rd_byte = 8'h00;
    w_rd_word = '0;
    if (w_rd_addr[5:4] == 2'b00) begin
      case (w_rd_addr[3:0])
        4'h0:                    w_rd_byte = r_config1;
        4'h1:                    w_rd_byte = r_config2;
        4'h2:                    w_rd_byte = {7'd0, r_new_meas};
        4'h3:                    w_rd_byte = r_int_mask;
        4'h4, 4'h5, 4'h6, 4'h7:  w_rd_byte = r_ovf[w_rd_addr[1:0]];
        4'h8, 4'h9:              w_rd_byte = r_stop_mask[w_rd_addr[0]];
        default:                 w_rd_byte = 8'h00;
      endcase
      w_rd_word = {w_rd_byte, {(MEAS_W-8){1'b0}}};
    end else if (w_rd_addr[5:4] == 2'b01 && w_rd_addr[3:0] < 4'd12) begin
      w_rd_word = r_meas[w_rd_addr[3:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cmd_last    = 1'b0;
    w_wr_commit   = 1'b0;
    w_rd_word_end = 1'b0;
    if (w_csb_rise) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_csb_fall) w_state_nxt = S_CMD;
        S_CMD: begin
          if (w_sclk_rise && r_bitcnt == c_CNT_W'(7)) begin
            w_cmd_last  = 1'b1;
            w_state_nxt = w_cmd_byte[6] ? S_WDATA : S_RDATA;
          end
        end
        S_WDATA: if (w_sclk_rise && w_word_last) w_wr_commit = 1'b1;
        S_RDATA: if (w_sclk_rise && w_word_last) w_rd_word_end = 1'b1;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_ai     <= 1'b0;
      r_addr   <= 6'd0;
      r_dout   <= 1'b0;
    end else if (w_csb_rise) begin
      r_bitcnt <= '0;
      r_dout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dout <= 1'b0;
          if (w_csb_fall) r_bitcnt <= '0;
        end
        S_CMD: begin
          if (w_sclk_rise) begin
            if (w_cmd_last) begin
              r_ai     <= w_cmd_byte[7];
              r_addr   <= w_cmd_byte[5:0];
              r_bitcnt <= '0;
              r_shift  <= w_rd_word;
            end else begin
              r_shift  <= w_wword;
              r_bitcnt <= r_bitcnt + c_CNT_W'(1);
            end
          end
        end
        S_WDATA: begin
          if (w_sclk_rise) begin
            r_shift <= w_wword;
            if (w_wr_commit) begin
              r_bitcnt <= '0;
              r_addr   <= w_next_addr;
            end else begin
              r_bitcnt <= r_bitcnt + c_CNT_W'(1);
            end
          end
        end
        S_RDATA: begin
          if (w_sclk_fall) begin
            r_dout  <= r_shift[MEAS_W-1];
            r_shift <= {r_shift[MEAS_W-2:0], 1'b0};
          end else if (w_sclk_rise) begin
            if (w_rd_word_end) begin
              r_bitcnt <= '0;
              r_addr   <= w_next_addr;
              r_shift  <= w_rd_word;
            end else begin
              r_bitcnt <= r_bitcnt + c_CNT_W'(1);
            end
          end
        end
        default: r_dout <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_config1    <= 8'h00;
      r_config2    <= 8'h40;
      r_int_mask   <= 8'h07;
      r_new_meas   <= 1'b0;
      r_start_meas <= 1'b0;
      r_intb       <= 1'b1;
      for (int i = 0; i < 4; i++) r_ovf[i] <= 8'hFF;
      for (int i = 0; i < 2; i++) r_stop_mask[i] <= 8'h00;
      for (int i = 0; i < c_NUM_MEAS; i++) r_meas[i] <= '0;
    end else begin
      r_start_meas <= 1'b0;
      if (w_wr_commit && r_addr[5:4] == 2'b00) begin
        case (r_addr[3:0])
          4'h0: begin
            r_config1    <= {w_wr_byte[7:1], 1'b0};
            r_start_meas <= w_wr_byte[0];
          end
          4'h1:                   r_config2 <= w_wr_byte;
          4'h3:                   r_int_mask <= w_wr_byte;
          4'h4, 4'h5, 4'h6, 4'h7: r_ovf[r_addr[1:0]] <= w_wr_byte;
          4'h8, 4'h9:             r_stop_mask[r_addr[0]] <= w_wr_byte;
          default: ;
        endcase
      end
      // A completing measurement takes priority over a simultaneous clear.
      if (meas_done)
        r_new_meas <= 1'b1;
      else if (w_wr_commit && r_addr == 6'h02 && w_wr_byte[0])
        r_new_meas <= 1'b0;
      r_intb <= ~(r_new_meas & r_int_mask[0]);
      if (meas_we && meas_addr < 4'd12) r_meas[meas_addr] <= meas_data;
    end
  end

  assign dout       = r_dout;
  assign intb       = r_intb;
  assign start_meas = r_start_meas;
  assign cfg1       = r_config1;
  assign cfg2       = r_config2;

endmodule
`default_nettype wire

// File: tb/tb_tdc7200_spi_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tdc7200_spi_responder                                        |
// | Brief    : Randomized bench with a word-level register model.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_tdc7200_spi_responder;

  localparam int HALF = 80;

  logic        clk, rstn, sclk, csb, din, dout, intb;
  logic        meas_we, meas_done, start_meas;
  logic [3:0]  meas_addr;
  logic [23:0] meas_data;
  logic [7:0]  cfg1, cfg2;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int intb_hi_cnt = 0;
  logic watch = 1'b0;

  logic [7:0]  m_reg [10];
  logic [23:0] m_meas [12];

  tdc7200_spi_responder #(.SYNC_STAGES(2), .MEAS_W(24)) dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .csb(csb), .din(din), .dout(dout),
    .intb(intb), .meas_we(meas_we), .meas_addr(meas_addr), .meas_data(meas_data),
    .meas_done(meas_done), .start_meas(start_meas), .cfg1(cfg1), .cfg2(cfg2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (start_meas) start_cnt++;
  always @(negedge clk) if (watch && intb) intb_hi_cnt++;

  task automatic model_reset();
    for (int i = 0; i < 10; i++) m_reg[i] = 8'h00;
    m_reg[1] = 8'h40;
    m_reg[3] = 8'h07;
    for (int i = 4; i < 8; i++) m_reg[i] = 8'hFF;
    for (int i = 0; i < 12; i++) m_meas[i] = 24'h0;
  endtask

  function automatic logic [23:0] model_read(input int a);
    if (a < 10) return {16'h0, m_reg[a]};
    if (a >= 16 && a < 28) return m_meas[a-16];
    return 24'h0;
  endfunction

  // Word-level view: walk the words after the command byte, applying complete writes.
  task automatic model_xfer(input logic [127:0] mosi, input int nbits,
                            output logic [127:0] exp_miso, output int starts);
    int a, pos, w;
    logic ai, rw;
    logic [7:0] cmd;
    logic [23:0] v;
    exp_miso = '0;
    starts = 0;
    if (nbits < 8) return;
    cmd = mosi[127:120];
    ai = cmd[7];
    rw = cmd[6];
    a = int'(cmd[5:0]);
    pos = 8;
    while (pos < nbits) begin
      w = (a < 16) ? 8 : 24;
      if (rw) begin
        if (pos + w > nbits) break;
        v = '0;
        for (int j = 0; j < w; j++) v = {v[22:0], mosi[127-pos-j]};
        if (a == 0) begin
          m_reg[0] = v[7:0] & 8'hFE;
          if (v[0]) starts++;
        end else if (a == 2) begin
          if (v[0]) m_reg[2] = 8'h00;
        end else if (a < 10) begin
          m_reg[a] = v[7:0];
        end
      end else begin
        v = model_read(a);
        for (int j = 0; j < w && pos + j < nbits; j++) exp_miso[127-pos-j] = v[w-1-j];
      end
      pos += w;
      a = ai ? (a + 1) % 64 : a;
    end
  endtask

  task automatic spi_begin();
    csb = 1'b0;
  endtask

  task automatic spi_bit(input logic b, output logic m);
    din = b;
    #(HALF);
    m = dout;
    sclk = 1'b1;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_end();
    #(HALF);
    csb = 1'b1;
    din = 1'b0;
    #200;
  endtask

  task automatic spi_xfer(input logic [127:0] mosi, input int nbits, output logic [127:0] miso);
    logic m;
    miso = '0;
    spi_begin();
    for (int i = 0; i < nbits; i++) begin
      spi_bit(mosi[127-i], m);
      miso[127-i] = m;
    end
    spi_end();
  endtask

  task automatic load_meas(input int idx, input logic [23:0] d);
    meas_we = 1'b1;
    meas_addr = 4'(idx);
    meas_data = d;
    #10;
    meas_we = 1'b0;
    if (idx < 12) m_meas[idx] = d;
  endtask

  task automatic pulse_done();
    meas_done = 1'b1;
    #10;
    meas_done = 1'b0;
    m_reg[2] = 8'h01;
  endtask

  task automatic run_xfer(input logic [127:0] mosi, input int nbits, input string name);
    logic [127:0] miso, exp_miso, mask, ones;
    int exp_starts, s0;
    logic exp_intb;
    s0 = start_cnt;
    model_xfer(mosi, nbits, exp_miso, exp_starts);
    spi_xfer(mosi, nbits, miso);
    ones = '1;
    mask = ~(ones >> nbits);
    exp_intb = ~(m_reg[2][0] & m_reg[3][0]);
    checks++;
    if ((miso & mask) !== (exp_miso & mask)) begin
      errors++;
      $display("FAIL %s miso got %h expected %h", name, miso & mask, exp_miso & mask);
    end
    checks++;
    if (cfg1 !== m_reg[0]) begin
      errors++;
      $display("FAIL %s cfg1 got %h expected %h", name, cfg1, m_reg[0]);
    end
    checks++;
    if (cfg2 !== m_reg[1]) begin
      errors++;
      $display("FAIL %s cfg2 got %h expected %h", name, cfg2, m_reg[1]);
    end
    checks++;
    if (intb !== exp_intb) begin
      errors++;
      $display("FAIL %s intb got %b expected %b", name, intb, exp_intb);
    end
    checks++;
    if (start_cnt - s0 != exp_starts) begin
      errors++;
      $display("FAIL %s start_meas pulses got %0d expected %0d", name, start_cnt - s0, exp_starts);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %b expected 0", dout); end
    checks++;
    if (intb !== 1'b1) begin errors++; $display("FAIL reset_intb got %b expected 1", intb); end
    checks++;
    if (start_meas !== 1'b0) begin errors++; $display("FAIL reset_start got %b expected 0", start_meas); end
    checks++;
    if (cfg1 !== 8'h00) begin errors++; $display("FAIL reset_cfg1 got %h expected 00", cfg1); end
    checks++;
    if (cfg2 !== 8'h40) begin errors++; $display("FAIL reset_cfg2 got %h expected 40", cfg2); end
    run_xfer({8'h03, 120'h0}, 16, "rd_int_mask");
    run_xfer({8'h84, 120'h0}, 40, "rd_ovf_ai");
  endtask

  task automatic test_abort();
    run_xfer({8'h41, 8'h00, 112'h0} | {16'h0, 5'b10101, 107'h0}, 13, "abort_wr");
    checks++;
    if (cfg2 !== 8'h40) begin errors++; $display("FAIL abort_cfg2 got %h expected 40", cfg2); end
    run_xfer({8'h01, 120'h0}, 16, "abort_follow_rd");
  endtask

  task automatic test_write_read();
    run_xfer({8'h41, 8'h83, 112'h0}, 16, "wr_cfg2");
    checks++;
    if (cfg2 !== 8'h83) begin errors++; $display("FAIL wr_cfg2_direct got %h expected 83", cfg2); end
    run_xfer({8'h01, 120'h0}, 16, "rd_cfg2");
  endtask

  task automatic test_meas_read();
    load_meas(0, 24'h00ABCD);
    run_xfer({8'h10, 120'h0}, 32, "rd_meas0");
    load_meas(11, 24'hF0F00F);
    run_xfer({8'h9B, 120'h0}, 8 + 24 + 24, "rd_meas11_ai");
  endtask

  task automatic test_ai_read();
    run_xfer({8'h88, 120'h0}, 24, "ai_rd_08_09");
    run_xfer({8'h88, 120'h0}, 32, "ai_rd_to_0a");
    run_xfer({8'h01, 120'h0}, 16, "ai_follow_rd");
  endtask

  task automatic test_start_meas();
    int s0;
    s0 = start_cnt;
    run_xfer({8'h40, 8'h01, 112'h0}, 16, "wr_cfg1_start");
    checks++;
    if (start_cnt - s0 != 1) begin errors++; $display("FAIL start_pulse_count got %0d expected 1", start_cnt - s0); end
    checks++;
    if (cfg1 !== 8'h00) begin errors++; $display("FAIL cfg1_selfclear got %h expected 00", cfg1); end
    run_xfer({8'h00, 120'h0}, 16, "rd_cfg1");
    run_xfer({8'hFF, 24'h123456, 8'h01, 88'h0}, 40, "wr_wrap_3f_00");
  endtask

  task automatic test_intb();
    logic m;
    pulse_done();
    checks++;
    if (intb !== 1'b1) begin errors++; $display("FAIL intb_latency got %b expected 1", intb); end
    #10;
    checks++;
    if (intb !== 1'b0) begin errors++; $display("FAIL intb_after_done got %b expected 0", intb); end
    run_xfer({8'h02, 120'h0}, 16, "rd_status_set");
    run_xfer({8'h42, 8'h01, 112'h0}, 16, "w1c_status");
    checks++;
    if (intb !== 1'b1) begin errors++; $display("FAIL intb_after_w1c got %b expected 1", intb); end
    pulse_done();
    #20;
    // Hold meas_done across the clear commit so both land in the same clock.
    intb_hi_cnt = 0;
    spi_begin();
    for (int i = 0; i < 8; i++) spi_bit(((8'h42 >> (7 - i)) & 8'h01) != 0, m);
    for (int i = 0; i < 7; i++) spi_bit(1'b0, m);
    din = 1'b1;
    meas_done = 1'b1;
    watch = 1'b1;
    #(HALF);
    sclk = 1'b1;
    #(HALF);
    sclk = 1'b0;
    meas_done = 1'b0;
    #20;
    watch = 1'b0;
    spi_end();
    checks++;
    if (intb_hi_cnt != 0) begin errors++; $display("FAIL set_wins_glitch got %0d high clks expected 0", intb_hi_cnt); end
    checks++;
    if (intb !== 1'b0) begin errors++; $display("FAIL set_wins_intb got %b expected 0", intb); end
    run_xfer({8'h42, 8'h01, 112'h0}, 16, "w1c_cleanup");
  endtask

  task automatic test_snapshot();
    logic m;
    logic [47:0] got;
    load_meas(0, 24'h5A5A5A);
    spi_begin();
    for (int i = 0; i < 8; i++) spi_bit(((8'h10 >> (7 - i)) & 8'h01) != 0, m);
    got = '0;
    for (int i = 0; i < 48; i++) begin
      if (i == 12) load_meas(0, 24'hC3C3C3);
      spi_bit(1'b0, m);
      got = {got[46:0], m};
    end
    spi_end();
    checks++;
    if (got !== {24'h5A5A5A, 24'hC3C3C3}) begin
      errors++;
      $display("FAIL snapshot got %h expected %h", got, {24'h5A5A5A, 24'hC3C3C3});
    end
  endtask

  task automatic test_reset_mid_read();
    logic m;
    logic [3:0] after;
    run_xfer({8'h41, 8'hAA, 112'h0}, 16, "pre_reset_wr");
    load_meas(5, 24'hFFFFFF);
    spi_begin();
    for (int i = 0; i < 8; i++) spi_bit(((8'h15 >> (7 - i)) & 8'h01) != 0, m);
    for (int i = 0; i < 6; i++) spi_bit(1'b0, m);
    rstn = 1'b0;
    #30;
    checks++;
    if (dout !== 1'b0) begin errors++; $display("FAIL midrst_dout got %b expected 0", dout); end
    checks++;
    if (cfg2 !== 8'h40) begin errors++; $display("FAIL midrst_cfg2 got %h expected 40", cfg2); end
    checks++;
    if (intb !== 1'b1) begin errors++; $display("FAIL midrst_intb got %b expected 1", intb); end
    rstn = 1'b1;
    after = '0;
    for (int i = 0; i < 4; i++) begin
      spi_bit(1'b0, m);
      after = {after[2:0], m};
    end
    spi_end();
    checks++;
    if (after !== 4'h0) begin errors++; $display("FAIL midrst_idle_dout got %h expected 0", after); end
    model_reset();
    run_xfer({8'h15, 120'h0}, 32, "post_reset_meas");
    run_xfer({8'h01, 120'h0}, 16, "post_reset_cfg2");
  endtask

  task automatic test_random();
    logic [127:0] mosi;
    logic [5:0] a;
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 2) == 0) load_meas($urandom_range(0, 11), 24'($urandom));
      case ($urandom_range(0, 3))
        0: a = 6'($urandom_range(0, 11));
        1: a = 6'($urandom_range(16, 29));
        2: a = 6'($urandom_range(60, 63));
        default: a = 6'($urandom_range(0, 63));
      endcase
      mosi = {$urandom, $urandom, $urandom, $urandom};
      mosi[127:120] = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a};
      run_xfer(mosi, 8 + $urandom_range(0, 48), "random");
    end
  endtask

  initial begin
    rstn = 1'b0; sclk = 1'b0; csb = 1'b1; din = 1'b0;
    meas_we = 1'b0; meas_addr = 4'h0; meas_data = 24'h0; meas_done = 1'b0;
    model_reset();
    #100;
    rstn = 1'b1;
    #100;
    test_reset();
    test_abort();
    test_write_read();
    test_meas_read();
    test_ai_read();
    test_start_meas();
    test_intb();
    test_snapshot();
    test_reset_mid_read();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
